// File: rtl/comparator_serial_ctrl.sv
// comparator_serial_ctrl: serial unsigned magnitude comparator.
// The operands are stepped MSB-first, two bits per clock, through one 2-bit
// compare slice. A start/done handshake frames each compare, and the result
// flags hold their value until the next accepted start.
// Optional macro COMPARATOR_SERIAL_EARLY_EXIT_EN: when it is defined, the
// compare finishes on the first unequal slice. When it is undefined (the
// default build), every compare has a fixed, constant-time latency.

// 2-bit unsigned compare slice. It uses the same equations as the
// structural 2-bit comparator.
module comparator_2bit_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  assign gt = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);
  assign lt = (~a[1] & b[1]) | (~(a[1] ^ b[1]) & ~a[0] & b[0]);
  assign eq = &(a ~^ b);
endmodule

module comparator_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_greater_B,
  output logic             A_equals_B,
  output logic             A_less_B
);
  localparam int SLICES = WIDTH / 2;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  // Odd or sub-2-bit widths cannot be sliced into pairs.
  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("comparator_serial_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             decided, res_gt, res_lt;
  logic             s_gt, s_eq, s_lt;
  logic             fin_gt, fin_lt, go_done;

  comparator_2bit_slice u_slice (
    .a  (sh_a[WIDTH-1 -: 2]),
    .b  (sh_b[WIDTH-1 -: 2]),
    .gt (s_gt),
    .eq (s_eq),
    .lt (s_lt)
  );

  // Final verdict at the moment RUN ends. An earlier decision wins; otherwise
  // the current slice decides. Both low means the operands are equal.
  always_comb begin
    fin_gt = decided ? res_gt : s_gt;
    fin_lt = decided ? res_lt : s_lt;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    go_done = (cnt == '0) || (!decided && !s_eq);
`else
    go_done = (cnt == '0);
`endif
  end

  // Control FSM, datapath shift and registered handshake/flag outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sh_a        <= '0;
      sh_b        <= '0;
      cnt         <= '0;
      decided     <= 1'b0;
      res_gt      <= 1'b0;
      res_lt      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      A_greater_B <= 1'b0;
      A_equals_B  <= 1'b0;
      A_less_B    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a        <= A;
            sh_b        <= B;
            cnt         <= CW'(SLICES - 1);
            decided     <= 1'b0;
            res_gt      <= 1'b0;
            res_lt      <= 1'b0;
            A_greater_B <= 1'b0;
            A_equals_B  <= 1'b0;
            A_less_B    <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          // The first unequal slice is the most significant one, so it sticks.
          if (!decided && !s_eq) begin
            decided <= 1'b1;
            res_gt  <= s_gt;
            res_lt  <= s_lt;
          end
          sh_a <= sh_a << 2;
          sh_b <= sh_b << 2;
          if (go_done) begin
            done        <= 1'b1;
            A_greater_B <= fin_gt;
            A_less_B    <= fin_lt;
            A_equals_B  <= ~(fin_gt | fin_lt);
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_comparator_serial_ctrl.sv
// Directed bench for comparator_serial_ctrl. It drives an 8-bit instance and a
// 2-bit instance. Inputs change and outputs are sampled on the falling edge.
// Cycle n is the low phase after rising edge n-1, and the start edge is edge 0.
module tb_comparator_serial_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       busy8, done8, gt8, eq8, lt8;
  logic       busy2, done2, gt2, eq2, lt2;

  int total = 0;
  int bad   = 0;

`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  always #5 clk = ~clk;

  comparator_serial_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8),
    .A_greater_B(gt8), .A_equals_B(eq8), .A_less_B(lt8)
  );

  comparator_serial_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
    .busy(busy2), .done(done2),
    .A_greater_B(gt2), .A_equals_B(eq2), .A_less_B(lt2)
  );

  // Launch one 8-bit compare and follow it until busy falls again. It returns
  // the done cycle (0 if none), the busy cycle count, the flags seen in cycle 1
  // and the flags seen at done. It ends in the first IDLE cycle.
  task automatic do_cmp8(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int bcnt,
                         output logic [2:0] f_run, output logic [2:0] f_done);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; bcnt = 0; f_run = {gt8, eq8, lt8}; f_done = 3'b000;
    for (int c = 1; c <= 20; c++) begin
      if (busy8) bcnt++;
      if (done8 && lat == 0) begin
        lat = c; f_done = {gt8, eq8, lt8};
      end
      if (!busy8) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy8, done8, gt8, eq8, lt8} !== 5'b0) begin
      bad++; $display("FAIL reset8: got %b want 00000", {busy8, done8, gt8, eq8, lt8});
    end
    total++;
    if ({busy2, done2, gt2, eq2, lt2} !== 5'b0) begin
      bad++; $display("FAIL reset2: got %b want 00000", {busy2, done2, gt2, eq2, lt2});
    end
    rst = 1'b0;
  endtask

  task automatic test_equal;
    int lat, bcnt; logic [2:0] fr, fd;
    do_cmp8(8'hA5, 8'hA5, lat, bcnt, fr, fd);
    total++; if (lat !== 5)       begin bad++; $display("FAIL eq_latency: got %0d want 5", lat); end
    total++; if (bcnt !== 5)      begin bad++; $display("FAIL eq_busy_cycles: got %0d want 5", bcnt); end
    total++; if (fr !== 3'b000)   begin bad++; $display("FAIL eq_flags_run: got %b want 000", fr); end
    total++; if (fd !== 3'b010)   begin bad++; $display("FAIL eq_flags_done: got %b want 010", fd); end
    repeat (3) @(negedge clk);
    total++;
    if ({busy8, done8, gt8, eq8, lt8} !== 5'b00010) begin
      bad++; $display("FAIL eq_flags_held: got %b want 00010", {busy8, done8, gt8, eq8, lt8});
    end
  endtask

  task automatic test_greater;
    int lat, bcnt, want; logic [2:0] fr, fd;
    want = EE ? 2 : 5;
    do_cmp8(8'h80, 8'h7F, lat, bcnt, fr, fd);
    total++; if (lat !== want)    begin bad++; $display("FAIL gt_latency: got %0d want %0d", lat, want); end
    total++; if (fr !== 3'b000)   begin bad++; $display("FAIL gt_flags_cleared: got %b want 000", fr); end
    total++; if (fd !== 3'b100)   begin bad++; $display("FAIL gt_flags_done: got %b want 100", fd); end
    total++; if ({gt8, eq8, lt8} !== 3'b100) begin bad++; $display("FAIL gt_flags_held: got %b want 100", {gt8, eq8, lt8}); end
  endtask

  task automatic test_less_lsb;
    int lat, bcnt; logic [2:0] fr, fd;
    do_cmp8(8'h12, 8'h13, lat, bcnt, fr, fd);
    total++; if (lat !== 5)       begin bad++; $display("FAIL lt_latency: got %0d want 5", lat); end
    total++; if (fd !== 3'b001)   begin bad++; $display("FAIL lt_flags_done: got %b want 001", fd); end
  endtask

  task automatic test_back_to_back;
    int lat, want2;
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h41; start8 = 1'b1;
    @(negedge clk);                       // cycle 1: the operands are already captured
    a8 = 8'hFF;
    total++;
    if ({busy8, gt8, eq8, lt8} !== 4'b1000) begin
      bad++; $display("FAIL b2b_run_start: got %b want 1000", {busy8, gt8, eq8, lt8});
    end
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done8) begin lat = c; break; end
      @(negedge clk);
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL b2b_latency1: got %0d want 5", lat); end
    total++; if ({gt8, eq8, lt8} !== 3'b001) begin bad++; $display("FAIL b2b_captured: got %b want 001", {gt8, eq8, lt8}); end
    @(negedge clk);                       // cycle 6: IDLE, the start held in DONE was ignored
    total++;
    if ({busy8, gt8, eq8, lt8} !== 4'b0001) begin
      bad++; $display("FAIL b2b_idle_gap: got %b want 0001", {busy8, gt8, eq8, lt8});
    end
    @(negedge clk);                       // cycle 7: next compare (0xFF vs 0x41) is running
    start8 = 1'b0;
    total++;
    if ({busy8, gt8, eq8, lt8} !== 4'b1000) begin
      bad++; $display("FAIL b2b_second_accept: got %b want 1000", {busy8, gt8, eq8, lt8});
    end
    want2 = EE ? 8 : 11;
    lat = 0;
    for (int c = 7; c <= 30; c++) begin
      if (done8) begin lat = c; break; end
      @(negedge clk);
    end
    total++; if (lat !== want2) begin bad++; $display("FAIL b2b_latency2: got %0d want %0d", lat, want2); end
    total++; if ({gt8, eq8, lt8} !== 3'b100) begin bad++; $display("FAIL b2b_result2: got %b want 100", {gt8, eq8, lt8}); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int pulses, lat, bcnt; logic [2:0] fr, fd;
    @(negedge clk);
    a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);                       // RUN cycle 1
    start8 = 1'b0;
    @(negedge clk);                       // RUN cycle 2
    rst = 1'b1;
    #1;
    total++;
    if ({busy8, done8, gt8, eq8, lt8} !== 5'b0) begin
      bad++; $display("FAIL rst_mid_drop: got %b want 00000", {busy8, done8, gt8, eq8, lt8});
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (done8 || busy8) pulses++;
      @(negedge clk);
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d active cycles want 0", pulses); end
    do_cmp8(8'h33, 8'h30, lat, bcnt, fr, fd);
    total++; if (lat !== 5)     begin bad++; $display("FAIL rst_mid_restart_lat: got %0d want 5", lat); end
    total++; if (fd !== 3'b100) begin bad++; $display("FAIL rst_mid_restart_flags: got %b want 100", fd); end
  endtask

  task automatic test_w2_exhaustive;
    int lat; logic [2:0] f, exp;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        a2 = 2'(a); b2 = 2'(b); start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0; f = 3'b000;
        for (int c = 1; c <= 10; c++) begin
          if (done2) begin lat = c; f = {gt2, eq2, lt2}; break; end
          @(negedge clk);
        end
        exp = {a > b, a == b, a < b};
        total++; if (lat !== 2) begin bad++; $display("FAIL w2_latency a=%0d b=%0d: got %0d want 2", a, b, lat); end
        total++; if (f !== exp) begin bad++; $display("FAIL w2_flags a=%0d b=%0d: got %b want %b", a, b, f, exp); end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_equal();
    test_greater();
    test_less_lsb();
    test_back_to_back();
    test_reset_mid();
    test_w2_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
